axis_vec_tx_80: RTL and testbench
=================================

# axis_vec_tx_80

AXI4-Stream transmitter that holds one 80-word input vector and streams it as a single TLAST-terminated packet. It is the master side for the 80-word matrix/vector input stream consumed by the 80-to-40 dot-product accelerator. Used by test harnesses and by on-chip sequencers to replay stored vectors into the accelerator without a DMA engine. A host writes the vector through a simple load port, pulses `start`, and the block emits 80 beats while honouring backpressure.

## Interface

Parameters:
- `DATA_WIDTH`, 32, width of each stream word and each buffer entry.
- `NUM_WORDS`, 80, words per packet (≥2); `ADDR_WIDTH` = clog2(`NUM_WORDS`).

Ports:
- `aclk`  in  1  single clock; all logic is rising-edge.
- `aresetn`  in  1  asynchronous, active-low reset.
- `wr_en`  in  1  load strobe; writes `wr_data` to `buf[wr_addr]`.
- `wr_addr`  in  ADDR_WIDTH  load address.
- `wr_data`  in  DATA_WIDTH  load data.
- `start`  in  1  single-cycle request to transmit the buffer.
- `busy`  out  1  high from the cycle after an accepted `start` until the final handshake.
- `done`  out  1  one-cycle pulse after the final beat is accepted.
- `OUTPUT_AXIS_TDATA`  out  DATA_WIDTH  current word.
- `OUTPUT_AXIS_TLAST`  out  1  high on word `NUM_WORDS`-1 only.
- `OUTPUT_AXIS_TVALID`  out  1  beat valid.
- `OUTPUT_AXIS_TREADY`  in  1  downstream ready.

## Operation

- Storage: `NUM_WORDS` x `DATA_WIDTH` register array; not cleared by reset (contents undefined after power-up).
- FSM states: IDLE, SEND, DONE.
  - IDLE: `TVALID`=0, `busy`=0. `start`=1 → SEND, index ← 0.
  - SEND: `TVALID`=1, `TDATA`=`buf[index]`, `TLAST`=(index==`NUM_WORDS`-1). On handshake (`TVALID`&&`TREADY`): if last → DONE, else index+1.
  - DONE: `done`=1 for exactly this cycle, `TVALID`=0, `busy`=0; unconditionally → IDLE next cycle. `start` asserted in DONE is accepted (→ SEND).
- Index counter ADDR_WIDTH bits; never exceeds `NUM_WORDS`-1; no wrap.
- `start` while in SEND is ignored (no restart, no queuing).
- `wr_en` while `busy`=1 is ignored (buffer frozen during transmit). `wr_en` with `wr_addr` ≥ `NUM_WORDS` is ignored. `wr_en` coincident with an accepted `start` performs the write before transmission starts.
- AXI rules: once `TVALID` rises it stays high until handshake; `TDATA`/`TLAST` stable while `TVALID`&&!`TREADY`. `TVALID` does not depend combinationally on `TREADY`.

## Timing

- Reset values (asynchronous): state IDLE, index 0, `TVALID`=0, `TLAST`=0, `busy`=0, `done`=0, `TDATA`=0.
- `start` sampled at edge N → `TVALID`=1 with word 0 from edge N+1 on.
- With `TREADY` held high: 80 beats on cycles N+1..N+80, `TLAST` on N+80, `done` on N+81; next `start` at N+81 gives `TVALID` at N+82.
- Each `TREADY` low cycle stretches the packet by one cycle; no beats are dropped or duplicated.
- Reset mid-packet: `TVALID` drops immediately (asynchronously); packet truncated without `TLAST`; no `done`. Buffer contents retained.

## Test plan

- Load `buf[i]` = 0x1000+i for i=0..79, `start`, `TREADY`=1 → 80 beats 0x1000..0x104F on consecutive cycles, `TLAST` only on 0x104F, `done` one cycle after, `busy` high 80 cycles.
- Same load, `TREADY` toggled pseudo-randomly (~50%) → identical 80-word sequence; `TDATA`/`TLAST` stable during every stall; `done` exactly once.
- `start` pulsed again mid-packet and `wr_en` to addr 5 with 0xDEAD mid-packet → stream unchanged, word 5 still 0x1005; next packet (started from DONE cycle, no gap) shows 0x1005 as well.
- `wr_en` at addr 80 with 0xBEEF, then addr 0 with 0xCAFE, then `start` → first beat 0xCAFE, no beat equals 0xBEEF.
- Assert `aresetn`=0 after beat 40 with `TREADY`=1 → `TVALID` low within the reset cycle, no `done`; after release `start` → full 80-beat packet from 0x1000 (buffer retained).
- `TREADY` held low for 20 cycles after `start` → `TVALID` stays 1, `TDATA`=0x1000 throughout, `busy`=1, no `done`.

Source files
------------

// File: rtl/axis_vec_tx_80.sv
// axis_vec_tx_80: replays a stored NUM_WORDS-word vector as one TLAST-terminated AXI4-Stream packet
// ports: aclk/aresetn clock and asynchronous active-low reset; wr_en/wr_addr/wr_data buffer load;
//        start/busy/done transfer control; OUTPUT_AXIS_* stream master side
module axis_vec_tx_80 #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WORDS  = 80,
  parameter int ADDR_WIDTH = $clog2(NUM_WORDS)
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] OUTPUT_AXIS_TDATA,
  output logic                  OUTPUT_AXIS_TLAST,
  output logic                  OUTPUT_AXIS_TVALID,
  input  logic                  OUTPUT_AXIS_TREADY
);
  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [DATA_WIDTH-1:0] mem_q [NUM_WORDS];
  logic last, wr_ok;
  // buffer is frozen while sending; the extra bit keeps the range check valid when NUM_WORDS is a power of two
  always_comb begin
    last = idx_q == ADDR_WIDTH'(NUM_WORDS - 1);
    wr_ok = wr_en && state_q != SEND && {1'b0, wr_addr} < (ADDR_WIDTH + 1)'(NUM_WORDS);
  end
  always_ff @(posedge aclk) if (wr_ok) mem_q[wr_addr] <= wr_data;
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      idx_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
    end
  end
  // DONE behaves like IDLE for start, so back-to-back packets need no gap cycle
  always_comb begin
    state_d = state_q == SEND ? (OUTPUT_AXIS_TREADY && last ? DONE : SEND) : (start ? SEND : IDLE);
    idx_d = state_q != SEND ? '0 : (OUTPUT_AXIS_TREADY && !last ? idx_q + ADDR_WIDTH'(1) : idx_q);
  end
  always_comb begin
    OUTPUT_AXIS_TVALID = state_q == SEND;
    OUTPUT_AXIS_TLAST = state_q == SEND && last;
    OUTPUT_AXIS_TDATA = state_q == SEND ? mem_q[idx_q] : '0;
    busy = state_q == SEND;
    done = state_q == DONE;
  end
endmodule

// File: tb/tb_axis_vec_tx_80.sv
// tb_axis_vec_tx_80: scoreboard bench for the vector stream transmitter
module tb_axis_vec_tx_80;
  typedef struct {logic [31:0] data; logic last;} beat_t;
  logic clk, aresetn, wr_en, start, busy, done, tlast, tvalid, tready;
  logic [6:0] wr_addr;
  logic [31:0] wr_data, tdata;
  logic [31:0] model_buf [80];
  beat_t exp_q [$];
  int checks, failures, done_cnt, beats;
  logic last_prev;
  axis_vec_tx_80 dut (
    .aclk(clk), .aresetn(aresetn), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .busy(busy), .done(done), .OUTPUT_AXIS_TDATA(tdata),
    .OUTPUT_AXIS_TLAST(tlast), .OUTPUT_AXIS_TVALID(tvalid), .OUTPUT_AXIS_TREADY(tready)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  task chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask
  task monitor();
    forever begin
      @(negedge clk);
      if (!aresetn) last_prev = 0;
      else begin
        chk("done_after_last", {31'b0, done}, {31'b0, last_prev});
        if (done) done_cnt++;
        last_prev = 0;
        if (tvalid) begin
          chk("beat_expected", {31'b0, exp_q.size() != 0}, 32'd1);
          if (exp_q.size() != 0) begin
            chk("tdata", tdata, exp_q[0].data);
            chk("tlast", {31'b0, tlast}, {31'b0, exp_q[0].last});
            chk("busy_in_send", {31'b0, busy}, 32'd1);
            if (tready) begin
              last_prev = exp_q[0].last;
              void'(exp_q.pop_front());
              beats++;
            end
          end
        end
      end
    end
  endtask
  task tick();
    @(posedge clk);
    #1;
  endtask
  task load(input logic [6:0] a, input logic [31:0] d);
    wr_en = 1; wr_addr = a; wr_data = d;
    if (a < 80) model_buf[a] = d;
    tick();
    wr_en = 0;
  endtask
  task push_pkt();
    for (int i = 0; i < 80; i++) exp_q.push_back('{model_buf[i], i == 79});
  endtask
  task kick(input bit do_wr, input logic [6:0] a, input logic [31:0] d);
    start = 1; wr_en = do_wr; wr_addr = a; wr_data = d;
    if (do_wr && a < 80) model_buf[a] = d;
    push_pkt();
    tick();
    start = 0; wr_en = 0;
  endtask
  task run_pkt(input bit rnd, input int inject_at, input bit chain, output int busy_cycles);
    int d0;
    bit ok;
    d0 = done_cnt; ok = 0; busy_cycles = 0;
    for (int c = 0; c < 1000; c++) begin
      tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      start = c == inject_at; wr_en = c == inject_at; wr_addr = 5; wr_data = 32'hDEAD;
      @(negedge clk);
      #1;
      if (busy) busy_cycles++;
      if (done_cnt != d0) begin ok = 1; break; end
      @(posedge clk);
      #1;
    end
    chk("pkt_done_in_budget", {31'b0, ok}, 32'd1);
    start = 0; wr_en = 0;
    if (chain) begin
      start = 1;
      push_pkt();
    end
    tick();
    start = 0;
  endtask
  initial begin
    int bc, d0, b0;
    checks = 0; failures = 0; done_cnt = 0; beats = 0; last_prev = 0;
    aresetn = 0; wr_en = 0; wr_addr = 0; wr_data = 0; start = 0; tready = 0;
    #2;
    chk("rst_tvalid", {31'b0, tvalid}, 0);
    chk("rst_tlast", {31'b0, tlast}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_tdata", tdata, 0);
    tick();
    tick();
    aresetn = 1;
    fork monitor(); join_none
    tick();
    for (int i = 0; i < 80; i++) load(7'(i), 32'h1000 + i);
    // full-rate packet
    d0 = done_cnt; b0 = beats;
    kick(0, 0, 0);
    chk("first_beat_valid", {31'b0, tvalid}, 1);
    chk("first_beat_data", tdata, 32'h1000);
    run_pkt(0, -1, 0, bc);
    chk("busy_cycles", bc, 80);
    chk("beats_full", beats - b0, 80);
    tick();
    chk("done_once_full", done_cnt - d0, 1);
    chk("idle_tvalid", {31'b0, tvalid}, 0);
    // random backpressure
    d0 = done_cnt; b0 = beats;
    kick(0, 0, 0);
    run_pkt(1, -1, 0, bc);
    tick();
    chk("beats_rand", beats - b0, 80);
    chk("done_once_rand", done_cnt - d0, 1);
    chk("queue_empty_rand", exp_q.size(), 0);
    // restart and write attempts mid-packet, then chained packet from DONE
    d0 = done_cnt; b0 = beats;
    kick(0, 0, 0);
    run_pkt(0, 10, 1, bc);
    chk("chain_no_gap", {31'b0, tvalid}, 1);
    chk("chain_word0", tdata, 32'h1000);
    run_pkt(0, -1, 0, bc);
    tick();
    chk("beats_chain", beats - b0, 160);
    chk("done_twice_chain", done_cnt - d0, 2);
    // out-of-range write ignored, write coincident with start lands first
    load(7'd80, 32'hBEEF);
    kick(1, 0, 32'hCAFE);
    chk("cafe_first", tdata, 32'hCAFE);
    run_pkt(0, -1, 0, bc);
    load(7'd0, 32'h1000);
    // reset after beat 40
    d0 = done_cnt; b0 = beats;
    kick(0, 0, 0);
    tready = 1;
    for (int c = 0; c < 200 && beats - b0 < 40; c++) begin
      @(negedge clk);
      #1;
    end
    chk("reached_beat40", beats - b0, 40);
    aresetn = 0;
    exp_q.delete();
    #1;
    chk("rst_async_tvalid", {31'b0, tvalid}, 0);
    chk("rst_async_busy", {31'b0, busy}, 0);
    tick();
    tick();
    aresetn = 1;
    tick();
    chk("no_done_on_reset", done_cnt - d0, 0);
    b0 = beats;
    kick(0, 0, 0);
    run_pkt(0, -1, 0, bc);
    chk("beats_after_reset", beats - b0, 80);
    // long stall on first beat
    d0 = done_cnt;
    tready = 0;
    kick(0, 0, 0);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      #1;
      chk("stall_tvalid", {31'b0, tvalid}, 1);
      chk("stall_tdata", tdata, 32'h1000);
      chk("stall_busy", {31'b0, busy}, 1);
      @(posedge clk);
      #1;
    end
    chk("stall_no_done", done_cnt - d0, 0);
    run_pkt(0, -1, 0, bc);
    tick();
    chk("queue_empty_end", exp_q.size(), 0);
    chk("done_once_stall", done_cnt - d0, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
